// File: rtl/rom_port_arbiter.sv
// Shares the program ROM's single combinational read port between the fetch and load ports.
// Define ROM_ARB_RR_EN for round-robin tie breaking; otherwise fetch always wins ties.
module rom_port_arbiter #(
  parameter int ROM_WORDS = 100,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [31:0]       if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  output logic              if_rsp_err,
  input  logic              if_rsp_ready,
  input  logic              ld_req_valid,
  input  logic [31:0]       ld_req_addr,
  output logic              ld_req_ready,
  output logic              ld_rsp_valid,
  output logic [31:0]       ld_rsp_data,
  output logic              ld_rsp_err,
  input  logic              ld_rsp_ready,
  output logic [31:0]       rom_addr,
  input  logic [31:0]       rom_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [29:0] ROM_WORDS_W = 30'(ROM_WORDS);

  typedef enum logic {IDLE, PEND} state_t;

  // Index 0 is the fetch port, index 1 the load port.
  logic [1:0]  req_valid;
  logic [31:0] req_addr [2];
  logic [1:0]  rsp_ready;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_err;
  logic [31:0] rsp_data [2];
  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        if_wins;
  logic        rom_err;
  logic [CNT_W-1:0] conflict_cnt_reg;

  assign req_valid   = {ld_req_valid, if_req_valid};
  assign req_addr[0] = if_req_addr;
  assign req_addr[1] = ld_req_addr;
  assign rsp_ready   = {ld_rsp_ready, if_rsp_ready};

`ifdef ROM_ARB_RR_EN
  logic rr_last_ld_reg;

  // Pointer remembers the last tie winner; the other port takes the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_ld_reg <= 1'b1;
    end else if (elig == 2'b11) begin
      rr_last_ld_reg <= grant[1];
    end
  end

  assign if_wins = rr_last_ld_reg;
`else
  assign if_wins = 1'b1;
`endif

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (elig == 2'b11) begin
        grant = if_wins ? 2'b01 : 2'b10;
      end else begin
        grant = elig;
      end
    end
  end

  always_comb begin
    rom_addr = 32'd0;
    if (grant[0]) begin
      rom_addr = req_addr[0];
    end else if (grant[1]) begin
      rom_addr = req_addr[1];
    end
  end

  assign rom_err = (rom_addr[1:0] != 2'b00) || (rom_addr[31:2] >= ROM_WORDS_W);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      state_t      state_reg;
      logic        err_reg;
      logic [31:0] data_reg;

      // A pending response with rsp_ready low blocks eligibility, so data/err stay frozen.
      assign elig[gi] = req_valid[gi] && ((state_reg == IDLE) || rsp_ready[gi]);

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= IDLE;
          err_reg   <= 1'b0;
          data_reg  <= 32'd0;
        end else begin
          case (state_reg)
            IDLE: if (grant[gi]) state_reg <= PEND;
            PEND: if (rsp_ready[gi] && !grant[gi]) state_reg <= IDLE;
            default: state_reg <= IDLE;
          endcase
          if (grant[gi]) begin
            err_reg  <= rom_err;
            data_reg <= rom_err ? 32'd0 : rom_data;
          end
        end
      end

      assign rsp_valid[gi] = (state_reg == PEND);
      assign rsp_err[gi]   = err_reg;
      assign rsp_data[gi]  = data_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_reg <= '0;
    end else if ((elig == 2'b11) && (conflict_cnt_reg != {CNT_W{1'b1}})) begin
      conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
    end
  end

  assign conflict_cnt = conflict_cnt_reg;

  assign if_req_ready = grant[0];
  assign ld_req_ready = grant[1];
  assign if_rsp_valid = rsp_valid[0];
  assign ld_rsp_valid = rsp_valid[1];
  assign if_rsp_err   = rsp_err[0];
  assign ld_rsp_err   = rsp_err[1];
  assign if_rsp_data  = rsp_data[0];
  assign ld_rsp_data  = rsp_data[1];

endmodule
